// File: rtl/alu_pkg.sv
// Shared opcode constants and buffer-state type for the ALU execution stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        FULL
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: (op, a, b) -> (result, zero, illegal, ovf).
// Signed overflow detection is built only when ALU_EXEC_OVF_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         illegal,
    output logic         ovf
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        result  = '0;
        illegal = 1'b0;
        unique case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

`ifdef ALU_EXEC_OVF_EN
    always_comb begin
        ovf = 1'b0;
        if (op == ALU_ADD)
            ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        else if (op == ALU_SUB)
            ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_exec.sv
// ALU execution stage: valid/ready in, one-cycle registered result out, 2-entry skid buffer.
// Optional macro ALU_EXEC_OVF_EN enables signed-overflow reporting on o_ovf.
module alu_exec
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [3:0]   i_aluControl,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_result,
    output logic         o_zero,
    output logic         o_illegal,
    output logic         o_ovf
);

    state_t       state;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         alu_illegal;
    logic         alu_ovf;
    logic [W-1:0] skid_result;
    logic         skid_zero;
    logic         skid_illegal;
    logic         skid_ovf;
    logic         accept;
    logic         pop;

    alu_core #(.W(W)) u_core (
        .op      (i_aluControl),
        .a       (i_a),
        .b       (i_b),
        .result  (alu_result),
        .zero    (alu_zero),
        .illegal (alu_illegal),
        .ovf     (alu_ovf)
    );

    assign o_ready = !i_rst && (state != FULL);
    assign o_valid = (state != EMPTY);
    assign accept  = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            state        <= EMPTY;
            o_result     <= '0;
            o_zero       <= 1'b0;
            o_illegal    <= 1'b0;
            o_ovf        <= 1'b0;
            // NOTE: the skid entry is reset too so discarded results cannot linger after reset.
            skid_result  <= '0;
            skid_zero    <= 1'b0;
            skid_illegal <= 1'b0;
            skid_ovf     <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        o_result  <= alu_result;
                        o_zero    <= alu_zero;
                        o_illegal <= alu_illegal;
                        o_ovf     <= alu_ovf;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept && pop) begin
                        o_result  <= alu_result;
                        o_zero    <= alu_zero;
                        o_illegal <= alu_illegal;
                        o_ovf     <= alu_ovf;
                    end else if (accept) begin
                        skid_result  <= alu_result;
                        skid_zero    <= alu_zero;
                        skid_illegal <= alu_illegal;
                        skid_ovf     <= alu_ovf;
                        state        <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // Never accepts here, so a pop simply promotes the skid entry.
                    if (pop) begin
                        o_result  <= skid_result;
                        o_zero    <= skid_zero;
                        o_illegal <= skid_illegal;
                        o_ovf     <= skid_ovf;
                        state     <= HOLD;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: vector table plus backpressure and reset-in-FULL sequences.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_EXEC_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [3:0]   i_aluControl;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic         o_zero;
    logic         o_illegal;
    logic         o_ovf;

    int total = 0;
    int bad   = 0;

    alu_exec #(.W(W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_aluControl (i_aluControl),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_zero       (o_zero),
        .o_illegal    (o_illegal),
        .o_ovf        (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         ill;
        logic         ov;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        i_aluControl = op;
        i_a          = a;
        i_b          = b;
        i_valid      = 1'b1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [W-1:0] res, input logic z,
                             input logic ill, input logic ov);
        check({name, ".valid"},   W'(o_valid),   W'(1'b1));
        check({name, ".result"},  o_result,      res);
        check({name, ".zero"},    W'(o_zero),    W'(z));
        check({name, ".illegal"}, W'(o_illegal), W'(ill));
        check({name, ".ovf"},     W'(o_ovf),     W'(ov));
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
        vecs[1]  = '{ALU_SUB, 32'd3,          32'd3,          32'd0,          1'b1, 1'b0, 1'b0};
        vecs[2]  = '{ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
        vecs[3]  = '{ALU_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0};
        vecs[4]  = '{ALU_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{ALU_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{ALU_OR,  32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b0, OVF_ON};
        vecs[8]  = '{ALU_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, OVF_ON};
        vecs[9]  = '{4'b0011, 32'd9,          32'd4,          32'd0,          1'b1, 1'b1, 1'b0};
        vecs[10] = '{ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0};
        vecs[11] = '{ALU_BAD, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1, 1'b0};

        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_ready      = 1'b1;
        i_aluControl = '0;
        i_a          = '0;
        i_b          = '0;
        tick();
        tick();
        check("rst.valid",  W'(o_valid),   '0);
        check("rst.ready",  W'(o_ready),   '0);
        check("rst.result", o_result,      '0);
        check("rst.zero",   W'(o_zero),    '0);
        check("rst.illegal", W'(o_illegal), '0);
        i_rst = 1'b0;
        #1;
        check("post_rst.ready", W'(o_ready), W'(1'b1));

        // Streaming with i_ready=1: each vector appears one cycle after acceptance.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d.ready", i), W'(o_ready), W'(1'b1));
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].ill, vecs[i].ov);
        end
        i_valid = 1'b0;
        tick();
        check("drain.valid", W'(o_valid), '0);

        // Backpressure: fill both entries, hold the third input, then release in order.
        i_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1);
        tick();
        check("bp1.valid",  W'(o_valid), W'(1'b1));
        check("bp1.result", o_result,    32'd2);
        check("bp1.ready",  W'(o_ready), W'(1'b1));
        drive(ALU_OR, 32'd1, 32'd2);
        tick();
        check("bp2.ready",  W'(o_ready), '0);
        check("bp2.result", o_result,    32'd2);
        drive(ALU_AND, 32'd3, 32'd1);
        tick();
        check("bp3.ready",  W'(o_ready), '0);
        check("bp3.result", o_result,    32'd2);
        tick();
        check("bp4.valid",  W'(o_valid), W'(1'b1));
        check("bp4.result", o_result,    32'd2);
        i_ready = 1'b1;
        tick();
        check("bp5.result", o_result,    32'd3);
        check("bp5.ready",  W'(o_ready), W'(1'b1));
        tick();
        check("bp6.result", o_result,    32'd1);
        check("bp6.valid",  W'(o_valid), W'(1'b1));
        i_valid = 1'b0;
        tick();
        check("bp7.valid",  W'(o_valid), '0);

        // Reset while FULL discards both buffered results.
        i_ready = 1'b0;
        drive(4'b0011, 32'd5, 32'd5);
        tick();
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        tick();
        check("rf.ready",   W'(o_ready),   '0);
        check("rf.illegal", W'(o_illegal), W'(1'b1));
        i_valid = 1'b0;
        i_rst   = 1'b1;
        i_ready = 1'b1;
        #1;
        check("rf.rst_ready", W'(o_ready), '0);
        tick();
        check("rf.valid",   W'(o_valid),   '0);
        check("rf.result",  o_result,      '0);
        check("rf.zero",    W'(o_zero),    '0);
        check("rf.illegal_clr", W'(o_illegal), '0);
        check("rf.ovf",     W'(o_ovf),     '0);
        i_rst = 1'b0;
        #1;
        check("rf.ready_after", W'(o_ready), W'(1'b1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rf.idle%0d.valid", i), W'(o_valid), '0);
        end
        drive(ALU_ADD, 32'd2, 32'd2);
        tick();
        check_out("rf.new", 32'd4, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        tick();
        check("rf.new_drain", W'(o_valid), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
Execution-side consumer of the 4-bit ALU control code produced by the MIPS ALU-control decoder. It accepts an operation code and two operands through a valid/ready handshake and computes the result and flags. Results are returned through a second valid/ready handshake, with one cycle of latency and full-throughput backpressure via a 2-entry skid buffer. It sits between the decode/ALU-control stage and the writeback/branch logic.

Parameters:
- W, 32, operand and result width in bits (≥2).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input transaction valid.
- o_ready  out  1  block can accept an input this cycle.
- i_aluControl  in  4  operation code.
- i_a  in  W  operand A (rs).
- i_b  in  W  operand B (rt/imm).
- o_valid  out  1  output transaction valid.
- i_ready  in  1  downstream accepts output.
- o_result  out  W  result.
- o_zero  out  1  o_result == 0.
- o_illegal  out  1  code was not a defined operation.
- o_ovf  out  1  signed overflow (add/sub only).

Behaviour:
- Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT; 1100 NOR; every other code, including 1111, is illegal.
- ADD/SUB wrap modulo 2^W. SLT: result = {W-1 zeros, signed(a) < signed(b)}. NOR = ~(a|b).
- Illegal code: result 0, o_illegal=1, o_zero=1, o_ovf=0. The transaction still completes normally and never stalls.
- Accept = i_valid & o_ready. Pop = o_valid & i_ready.
- Latency: an input accepted at edge N is visible on the outputs after edge N (o_valid=1 in cycle N+1). Order is strictly preserved.
- State machine (registered state):
  - EMPTY:
    - accept → HOLD; output register loaded.
  - HOLD:
    - accept & pop → HOLD; output register loaded with the new result.
    - accept & !pop → FULL; skid register loaded.
    - !accept & pop → EMPTY.
    - otherwise stay.
  - FULL:
    - pop → HOLD; output register ← skid.
    - otherwise stay.
  - The FULL state never accepts.
- o_valid = (state != EMPTY). o_ready = !i_rst & (state != FULL).
- Output fields (o_result, o_zero, o_illegal, o_ovf) are registered and change only on a pop or on a load from EMPTY. They are stable while o_valid & !i_ready.
- i_valid with o_ready=0: inputs are ignored. Upstream must hold them.
- Reset: state EMPTY; o_valid=0; o_result=0; o_zero=0; o_illegal=0; o_ovf=0; skid contents cleared. Reset mid-operation discards both buffered results, and no pop is signalled for them. o_ready=0 in any cycle with i_rst=1.
- Simultaneous accept and pop in FULL is impossible because o_ready=0.

Optional Feature:
- Macro ALU_EXEC_OVF_EN.
- Defined: o_ovf computed.
  - ADD: sign(a)==sign(b) and sign(result)!=sign(a).
  - SUB: sign(a)!=sign(b) and sign(result)!=sign(a).
  - All other ops: 0.
- Undefined: o_ovf is constant 0 and no overflow logic is generated. The port remains present.

Decomposition:
- Package alu_pkg holds:
  - 4-bit localparam opcode constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_BAD (1111).
  - The state enum type {EMPTY, HOLD, FULL}.
- One combinational sub-module, alu_core: (op, a, b) → (result, zero, illegal, ovf).
  - Instantiated once on the input side.
  - Its outputs are captured into the output or skid register.

Test Plan:
- W=32, i_ready=1, ADD a=5 b=7 → one cycle later o_valid=1, o_result=12, o_zero=0, o_ovf=0.
- SUB a=3 b=3 → o_result=0, o_zero=1. SLT a=0xFFFFFFFF b=1 → o_result=1. NOR a=0 b=0 → o_result=0xFFFFFFFF.
- With ALU_EXEC_OVF_EN: ADD a=0x7FFFFFFF b=1 → o_result=0x80000000, o_ovf=1. Without the macro → o_ovf=0.
- Code 0011 → o_illegal=1, o_result=0, o_zero=1, and the next transaction is still accepted.
- Backpressure: i_ready=0 with three back-to-back inputs (ADD 1+1, OR 1|2, AND 3&1):
  - State reaches FULL after the 2nd accept; o_ready=0; the 3rd input is held.
  - Raise i_ready → outputs 2, 3, 1 in order with no loss or duplication.
  - o_result is stable while stalled.
- Reset in FULL state → next cycle o_valid=0, all outputs 0. After i_rst drops, o_ready=1 and buffered results never appear.
